// File: rtl/pwm_freq_sequencer.sv
// PWM carrier generator with a shared half-period counter and glitch-free frequency switching.
// Frequency changes (host select or auto sweep) only take effect at the end of a full period.
module pwm_freq_sequencer #(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_en,
    input  logic               sel_valid,
    input  logic [2:0]         sel_idx,
    output logic               sel_ready,
    output logic               sel_err,
    input  logic               sweep_en,
    input  logic [SWEEP_W-1:0] sweep_periods,
    output logic               pwm_clk,
    output logic               period_tick,
    output logic [2:0]         cur_idx,
    output logic               busy
);

    typedef enum logic [1:0] {StStop, StRun, StPend} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         cur_idx_q, cur_idx_d;
    logic [2:0]         pend_idx_q, pend_idx_d;
    logic               pwm_clk_q, pwm_clk_d;
    logic               period_tick_q, period_tick_d;
    logic               sel_err_q, sel_err_d;
    logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;

    logic [CNT_W-1:0]   tc;
    logic               tc_hit;
    logic               pe;
    logic               accept;
    logic               host_sel;
    logic [SWEEP_W-1:0] sweep_max;
    logic [SWEEP_W-1:0] sweep_inc;
    logic [2:0]         sweep_next_idx;

    // Terminal counts: half period is tc+1 cycles of the 100 MHz clock.
    always_comb begin
        unique case (cur_idx_q)
            3'd0:    tc = CNT_W'(1999);
            3'd1:    tc = CNT_W'(999);
            3'd2:    tc = CNT_W'(666);
            3'd3:    tc = CNT_W'(499);
            3'd4:    tc = CNT_W'(399);
            3'd5:    tc = CNT_W'(332);
            3'd6:    tc = CNT_W'(285);
            default: tc = CNT_W'(1999);
        endcase
    end

    assign sel_ready      = (state_q != StPend);
    assign accept         = sel_valid && sel_ready;
    assign host_sel       = accept && (sel_idx != 3'd7);
    assign tc_hit         = (cnt_q == tc);
    assign pe             = (state_q != StStop) && tc_hit && pwm_clk_q;
    assign sweep_max      = (sweep_periods == '0) ? SWEEP_W'(1) : sweep_periods;
    assign sweep_inc      = sweep_cnt_q + SWEEP_W'(1);
    assign sweep_next_idx = (cur_idx_q == 3'd6) ? 3'd0 : cur_idx_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cur_idx_d     = cur_idx_q;
        pend_idx_d    = pend_idx_q;
        pwm_clk_d     = pwm_clk_q;
        period_tick_d = 1'b0;
        sel_err_d     = accept && (sel_idx == 3'd7);
        sweep_cnt_d   = sweep_en ? sweep_cnt_q : '0;

        unique case (state_q)
            StStop: begin
                cnt_d       = '0;
                pwm_clk_d   = 1'b0;
                sweep_cnt_d = '0;
                if (host_sel) begin
                    cur_idx_d = sel_idx;
                end
                if (run_en) begin
                    state_d = StRun;
                end
            end
            StRun, StPend: begin
                if (tc_hit) begin
                    cnt_d     = '0;
                    pwm_clk_d = ~pwm_clk_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                period_tick_d = pe;

                if (state_q == StRun) begin
                    if (pe && !run_en) begin
                        // Stopping at this boundary: a simultaneous select loads directly.
                        state_d     = StStop;
                        sweep_cnt_d = '0;
                        if (host_sel) begin
                            cur_idx_d = sel_idx;
                        end
                    end else if (host_sel) begin
                        pend_idx_d  = sel_idx;
                        state_d     = StPend;
                        sweep_cnt_d = '0;
                    end else if (pe && sweep_en) begin
                        if (sweep_inc >= sweep_max) begin
                            cur_idx_d   = sweep_next_idx;
                            sweep_cnt_d = '0;
                        end else begin
                            sweep_cnt_d = sweep_inc;
                        end
                    end
                end else if (pe) begin
                    cur_idx_d   = pend_idx_q;
                    sweep_cnt_d = '0;
                    state_d     = run_en ? StRun : StStop;
                end
            end
            default: begin
                state_d = StStop;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StStop;
            cnt_q         <= '0;
            cur_idx_q     <= 3'd0;
            pend_idx_q    <= 3'd0;
            pwm_clk_q     <= 1'b0;
            period_tick_q <= 1'b0;
            sel_err_q     <= 1'b0;
            sweep_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_idx_q     <= cur_idx_d;
            pend_idx_q    <= pend_idx_d;
            pwm_clk_q     <= pwm_clk_d;
            period_tick_q <= period_tick_d;
            sel_err_q     <= sel_err_d;
            sweep_cnt_q   <= sweep_cnt_d;
        end
    end

    assign pwm_clk     = pwm_clk_q;
    assign period_tick = period_tick_q;
    assign sel_err     = sel_err_q;
    assign cur_idx     = cur_idx_q;
    assign busy        = (state_q != StStop);

endmodule

// File: tb/tb_pwm_freq_sequencer.sv
// Directed bench for pwm_freq_sequencer: a STOP-state select table plus hand-written
// multi-cycle sequences for period timing, pending switches, sweep, stop and reset.
module tb_pwm_freq_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_en;
    logic       sel_valid;
    logic [2:0] sel_idx;
    logic       sel_ready;
    logic       sel_err;
    logic       sweep_en;
    logic [7:0] sweep_periods;
    logic       pwm_clk;
    logic       period_tick;
    logic [2:0] cur_idx;
    logic       busy;

    pwm_freq_sequencer #(
        .CNT_W  (12),
        .SWEEP_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_en       (run_en),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .sel_ready    (sel_ready),
        .sel_err      (sel_err),
        .sweep_en     (sweep_en),
        .sweep_periods(sweep_periods),
        .pwm_clk      (pwm_clk),
        .period_tick  (period_tick),
        .cur_idx      (cur_idx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int tick_cnt = 0;

    always @(negedge clk) begin
        if (period_tick) tick_cnt <= tick_cnt + 1;
    end

    typedef struct {
        logic       valid;
        logic [2:0] idx;
        logic [2:0] exp_idx;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_toggle(output int n);
        logic prev;
        prev = pwm_clk;
        n = 0;
        do begin
            step();
            n++;
        end while (pwm_clk == prev && n < 5000);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!period_tick && n < 5000);
        chk("tick_seen", period_tick, 1);
    endtask

    task automatic wait_idx(input logic [2:0] idx);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (cur_idx != idx && n < 5000);
        chk("idx_reached", cur_idx, idx);
    endtask

    task automatic select(input logic [2:0] idx);
        sel_valid = 1'b1;
        sel_idx   = idx;
        step();
        sel_valid = 1'b0;
    endtask

    initial begin
        int n;
        int t0;

        rst = 1'b1;
        run_en = 1'b0;
        sel_valid = 1'b0;
        sel_idx = 3'd0;
        sweep_en = 1'b0;
        sweep_periods = 8'd0;

        // Reset state
        step();
        step();
        chk("rst_sel_ready", sel_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pwm", pwm_clk, 0);
        chk("rst_idx", cur_idx, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_err", sel_err, 0);
        rst = 1'b0;
        step();

        // Selects while stopped load at once; index 7 only pulses sel_err
        vecs[0] = '{valid: 1'b1, idx: 3'd3, exp_idx: 3'd3, exp_err: 1'b0};
        vecs[1] = '{valid: 1'b1, idx: 3'd7, exp_idx: 3'd3, exp_err: 1'b1};
        vecs[2] = '{valid: 1'b0, idx: 3'd5, exp_idx: 3'd3, exp_err: 1'b0};
        vecs[3] = '{valid: 1'b1, idx: 3'd6, exp_idx: 3'd6, exp_err: 1'b0};
        vecs[4] = '{valid: 1'b1, idx: 3'd0, exp_idx: 3'd0, exp_err: 1'b0};
        vecs[5] = '{valid: 1'b1, idx: 3'd7, exp_idx: 3'd0, exp_err: 1'b1};
        vecs[6] = '{valid: 1'b1, idx: 3'd6, exp_idx: 3'd6, exp_err: 1'b0};
        for (int i = 0; i < 7; i++) begin
            sel_valid = vecs[i].valid;
            sel_idx   = vecs[i].idx;
            step();
            chk($sformatf("tbl%0d_idx", i), cur_idx, vecs[i].exp_idx);
            chk($sformatf("tbl%0d_err", i), sel_err, vecs[i].exp_err);
            chk($sformatf("tbl%0d_busy", i), busy, 0);
        end
        sel_valid = 1'b0;

        // idx 6: 286-cycle halves, one tick per 572-cycle period
        run_en = 1'b1;
        wait_toggle(n);
        chk("idx6_first_rise", n, 287);
        chk("idx6_busy", busy, 1);
        t0 = tick_cnt;
        wait_toggle(n);
        chk("idx6_high", n, 286);
        chk("idx6_tick_at_fall", period_tick, 1);
        wait_toggle(n);
        chk("idx6_low", n, 286);
        chk("idx6_one_tick", tick_cnt - t0, 1);

        // Mid-period switch to idx 0 waits for period end
        repeat (100) step();
        select(3'd0);
        chk("pend_not_ready", sel_ready, 0);
        chk("pend_old_idx", cur_idx, 6);
        wait_toggle(n);
        chk("pend_rest_of_high", n, 185);
        chk("pend_applied_idx", cur_idx, 0);
        chk("pend_ready_again", sel_ready, 1);
        wait_toggle(n);
        chk("idx0_low", n, 2000);
        wait_toggle(n);
        chk("idx0_high", n, 2000);

        // Illegal index while running
        select(3'd7);
        chk("run_err_pulse", sel_err, 1);
        chk("run_err_idx", cur_idx, 0);
        chk("run_err_busy", busy, 1);
        chk("run_err_ready", sel_ready, 1);
        step();
        chk("run_err_cleared", sel_err, 0);

        // Sweep every 2 periods from idx 5, wrapping 6 -> 0
        select(3'd5);
        wait_idx(3'd5);
        sweep_en = 1'b1;
        sweep_periods = 8'd2;
        wait_tick();
        chk("sweep_pe1", cur_idx, 5);
        wait_tick();
        chk("sweep_pe2", cur_idx, 6);
        wait_tick();
        chk("sweep_pe3", cur_idx, 6);
        wait_tick();
        chk("sweep_pe4_wrap", cur_idx, 0);
        sweep_en = 1'b0;

        // run_en drop mid-period on idx 3: period completes, then stop low
        select(3'd3);
        wait_idx(3'd3);
        wait_toggle(n);
        chk("idx3_rise", n, 500);
        repeat (200) step();
        run_en = 1'b0;
        wait_toggle(n);
        chk("idx3_rest_high", n, 300);
        chk("stop_busy", busy, 0);
        chk("stop_tick", period_tick, 1);
        repeat (600) step();
        chk("stop_pwm_low", pwm_clk, 0);
        chk("stop_busy_held", busy, 0);
        chk("stop_idx", cur_idx, 3);

        // Reset in the middle of a pending switch
        run_en = 1'b1;
        wait_toggle(n);
        chk("idx3_restart_rise", n, 501);
        select(3'd1);
        chk("pend2_not_ready", sel_ready, 0);
        #3 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pwm", pwm_clk, 0);
        chk("midrst_idx", cur_idx, 0);
        chk("midrst_ready", sel_ready, 1);
        chk("midrst_tick", period_tick, 0);
        run_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("postrst_idx", cur_idx, 0);
        chk("postrst_busy", busy, 0);
        run_en = 1'b1;
        wait_toggle(n);
        chk("postrst_rise", n, 2001);
        wait_toggle(n);
        chk("postrst_high", n, 2000);
        chk("postrst_no_pending", cur_idx, 0);
        run_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
